// File: rtl/load_store_unit_if.sv
// load_store_unit_if: MEM-stage request, load result and data-memory bus of the load/store unit.
interface load_store_unit_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            Funct3;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [DATA_W-1:0]     rd;
    logic                  stall;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic                  mem_re;
    logic [3:0]            mem_we;
    logic [DATA_W-1:0]     mem_wd;
    logic [DATA_W-1:0]     mem_rd;
    logic [15:0]           misalign_cnt;
    modport master (
        output MemRead, MemWrite, Funct3, a, wd, mem_rd,
        input  rd, stall, mem_addr, mem_re, mem_we, mem_wd, misalign_cnt
    );
    modport slave (
        input  MemRead, MemWrite, Funct3, a, wd, mem_rd,
        output rd, stall, mem_addr, mem_re, mem_we, mem_wd, misalign_cnt
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte-lane alignment and two-cycle split sequencing of loads/stores to word memory.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    load_store_unit_if.slave bus
);
    typedef enum logic {IDLE, SECOND} state_t;
    state_t                state;
    logic [31:0]           hold;
    logic [CNT_W-1:0]      cnt;
    logic                  ld, st, sec, split, go, zext;
    logic [1:0]            off;
    logic [2:0]            sz;
    logic [3:0]            mask;
    logic [7:0]            be;
    logic [63:0]           wd_sh, rd_cat, rd_sh;
    logic [31:0]           raw, ext;
    logic [DM_ADDRESS-3:0] w;
    assign ld    = bus.MemRead;
    assign st    = bus.MemWrite & ~bus.MemRead;
    assign sec   = state == SECOND;
    assign off   = bus.a[1:0];
    assign w     = bus.a[DM_ADDRESS-1:2];
    assign zext  = bus.Funct3[2];
    assign sz    = bus.Funct3[1:0] == 2'd0 ? 3'd1 : bus.Funct3[1:0] == 2'd1 ? 3'd2 : 3'd4;
    assign mask  = bus.Funct3[1:0] == 2'd0 ? 4'h1 : bus.Funct3[1:0] == 2'd1 ? 4'h3 : 4'hF;
    assign split = ({1'b0, off} + sz) > 3'd4;
    assign go    = ~reset & ~sec & (ld | st) & split;
    // Lanes and data are positioned across an 8-byte window: low word first, high word in SECOND.
    assign be     = {4'h0, mask} << off;
    assign wd_sh  = {32'h0, bus.wd} << {off, 3'b000};
    assign rd_cat = sec ? {bus.mem_rd, hold} : {32'h0, bus.mem_rd};
    assign rd_sh  = rd_cat >> {off, 3'b000};
    assign raw    = rd_sh[31:0];
    assign ext    = sz == 3'd1 ? {{24{~zext & raw[7]}}, raw[7:0]}
                  : sz == 3'd2 ? {{16{~zext & raw[15]}}, raw[15:0]} : raw;
    assign bus.stall        = go;
    assign bus.mem_addr     = {w + {{(DM_ADDRESS-3){1'b0}}, sec}, 2'b00};
    assign bus.mem_re       = ld;
    assign bus.mem_we       = (reset | ~st) ? 4'h0 : sec ? be[7:4] : be[3:0];
    assign bus.mem_wd       = sec ? wd_sh[63:32] : wd_sh[31:0];
    assign bus.rd           = (reset | ~ld | go) ? 32'h0 : ext;
    assign bus.misalign_cnt = 16'(cnt);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            hold  <= 32'h0;
            cnt   <= '0;
        end else if (sec) begin
            state <= IDLE;
            cnt   <= &cnt ? cnt : cnt + 1'b1;
        end else if (go) begin
            state <= SECOND;
            if (ld) hold <= bus.mem_rd;
        end
    end
endmodule
